// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : SPI mode-0 target emulating a serial flash command subset
//               (READ 03, PP 02, WREN 06, WRDI 04, RDSR 05, RDID 9F) on top of
//               a simple synchronous byte memory port. All SPI pins are
//               oversampled into clk; nothing is clocked by spi_sclk.
//               Optional feature macro: SPI_FLASH_RESP_FAST_READ_EN enables
//               FAST READ (0B) with 8 dummy clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int          SYNC     = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_csel,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic              wel
);

`ifdef SPI_FLASH_RESP_FAST_READ_EN
    localparam logic c_FAST_READ = 1'b1;
`else
    localparam logic c_FAST_READ = 1'b0;
`endif

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_CMD    = 4'd1;
    localparam logic [3:0] c_ST_ADDR   = 4'd2;
    localparam logic [3:0] c_ST_RD     = 4'd3;
    localparam logic [3:0] c_ST_ID     = 4'd4;
    localparam logic [3:0] c_ST_STAT   = 4'd5;
    localparam logic [3:0] c_ST_PP     = 4'd6;
    localparam logic [3:0] c_ST_IGNORE = 4'd7;
    localparam logic [3:0] c_ST_DUMMY  = 4'd8;

    localparam logic [1:0] c_OP_READ = 2'd0;
    localparam logic [1:0] c_OP_PP   = 2'd1;
    localparam logic [1:0] c_OP_FAST = 2'd2;

    logic [SYNC-1:0]   r_sclk_sync;
    logic [SYNC-1:0]   r_csel_sync;
    logic [SYNC-1:0]   r_mosi_sync;
    logic              r_sclk_prev;
    logic              r_csel_prev;

    logic [3:0]        r_state;
    logic [3:0]        w_state_next;

    logic [2:0]        r_bitcnt;
    logic [6:0]        r_rx;
    logic [22:0]       r_addr_sr;
    logic [7:0]        r_tx;
    logic [1:0]        r_byte_idx;
    logic [1:0]        r_op;
    logic              r_pp_done;
    logic              r_rd_wait;
    logic              r_miso;
    logic              r_wel;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_sclk_s;
    logic              w_csel_s;
    logic              w_mosi_s;
    logic              w_csel_fall;
    logic              w_csel_rise;
    logic              w_rise_ok;
    logic              w_fall_ok;
    logic              w_byte_done;
    logic [7:0]        w_rx_next;
    logic [23:0]       w_addr_full;
    logic [ADDR_W-1:0] w_addr_load;
    logic [7:0]        w_stat;
    logic [7:0]        w_id_byte;

    assign w_sclk_s    = r_sclk_sync[SYNC-1];
    assign w_csel_s    = r_csel_sync[SYNC-1];
    assign w_mosi_s    = r_mosi_sync[SYNC-1];
    assign w_csel_fall = r_csel_prev & ~w_csel_s;
    assign w_csel_rise = ~r_csel_prev & w_csel_s;
    // A chip-select edge in the same clk masks any sclk edge.
    assign w_rise_ok   = w_sclk_s & ~r_sclk_prev & ~w_csel_rise & ~w_csel_fall
                         & (r_state != c_ST_IDLE);
    assign w_fall_ok   = ~w_sclk_s & r_sclk_prev & ~w_csel_rise & ~w_csel_fall
                         & (r_state != c_ST_IDLE);
    assign w_byte_done = w_rise_ok & (r_bitcnt == 3'd7);
    assign w_rx_next   = {r_rx, w_mosi_s};
    assign w_addr_full = {r_addr_sr, w_mosi_s};
    assign w_stat      = {6'b0, r_wel, 1'b0};
    assign w_id_byte   = (r_byte_idx == 2'd1) ? JEDEC_ID[15:8] :
                         (r_byte_idx == 2'd2) ? JEDEC_ID[7:0]  : 8'h00;

    // Received 24-bit address fitted to the memory address width.
    generate
        if (ADDR_W > 24) begin : g_addr_wide
            assign w_addr_load = {{(ADDR_W-24){1'b0}}, w_addr_full};
        end else begin : g_addr_fit
            assign w_addr_load = w_addr_full[ADDR_W-1:0];
        end
    endgenerate

    // Pin synchronisers and previous-sample registers for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sclk_sync <= '0;
            r_csel_sync <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_csel_prev <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC-2:0], spi_sclk};
            r_csel_sync <= {r_csel_sync[SYNC-2:0], spi_csel};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], spi_mosi};
            r_sclk_prev <= w_sclk_s;
            r_csel_prev <= w_csel_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: chip-select edges first, then byte-boundary decisions.
    always_comb begin
        w_state_next = r_state;
        if (w_csel_fall) begin
            w_state_next = c_ST_CMD;
        end else if (w_csel_rise) begin
            w_state_next = c_ST_IDLE;
        end else if (w_byte_done) begin
            case (r_state)
                c_ST_CMD: begin
                    case (w_rx_next)
                        8'h9F:   w_state_next = c_ST_ID;
                        8'h05:   w_state_next = c_ST_STAT;
                        8'h03:   w_state_next = c_ST_ADDR;
                        8'h02:   w_state_next = r_wel ? c_ST_ADDR : c_ST_IGNORE;
                        8'h0B:   w_state_next = c_FAST_READ ? c_ST_ADDR : c_ST_IGNORE;
                        default: w_state_next = c_ST_IGNORE;
                    endcase
                end
                c_ST_ADDR: begin
                    if (r_byte_idx == 2'd2) begin
                        if (r_op == c_OP_PP) begin
                            w_state_next = c_ST_PP;
                        end else if (r_op == c_OP_FAST) begin
                            w_state_next = c_ST_DUMMY;
                        end else begin
                            w_state_next = c_ST_RD;
                        end
                    end
                end
                c_ST_DUMMY: w_state_next = c_ST_RD;
                default:    w_state_next = r_state;
            endcase
        end
    end

    // FSM outputs: miso is driven only in data-returning states while selected.
    always_comb begin
        spi_miso_oe = 1'b0;
        if (!w_csel_s) begin
            case (r_state)
                c_ST_RD, c_ST_ID, c_ST_STAT, c_ST_DUMMY: spi_miso_oe = 1'b1;
                default:                                 spi_miso_oe = 1'b0;
            endcase
        end
    end

    // Datapath: bit shifting, memory strobes, tx loading and write-enable latch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bitcnt    <= 3'd0;
            r_rx        <= 7'd0;
            r_addr_sr   <= 23'd0;
            r_tx        <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_op        <= c_OP_READ;
            r_pp_done   <= 1'b0;
            r_rd_wait   <= 1'b0;
            r_miso      <= 1'b0;
            r_wel       <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_rd_wait <= r_mem_rd;
            // Page program advances within the 256-byte page after each write.
            if (r_mem_wr) begin
                r_mem_addr[7:0] <= r_mem_addr[7:0] + 8'd1;
            end
            if (w_csel_fall) begin
                r_bitcnt   <= 3'd0;
                r_tx       <= 8'd0;
                r_miso     <= 1'b0;
                r_byte_idx <= 2'd0;
                r_pp_done  <= 1'b0;
            end else if (w_csel_rise) begin
                r_bitcnt <= 3'd0;
                if ((r_state == c_ST_PP) && r_pp_done) begin
                    r_wel <= 1'b0;
                end
            end else if (r_state != c_ST_IDLE) begin
                // Read data is used only if the transaction is still in RD.
                if (r_rd_wait && (r_state == c_ST_RD)) begin
                    r_tx <= mem_rdata;
                end
                if (w_rise_ok) begin
                    r_rx     <= w_rx_next[6:0];
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_state == c_ST_ADDR) begin
                        r_addr_sr <= w_addr_full[22:0];
                    end
                    if (w_byte_done) begin
                        case (r_state)
                            c_ST_CMD: begin
                                case (w_rx_next)
                                    8'h9F: begin
                                        r_tx       <= JEDEC_ID[23:16];
                                        r_byte_idx <= 2'd1;
                                    end
                                    8'h05:   r_tx  <= w_stat;
                                    8'h06:   r_wel <= 1'b1;
                                    8'h04:   r_wel <= 1'b0;
                                    8'h02:   r_op  <= c_OP_PP;
                                    8'h0B:   r_op  <= c_OP_FAST;
                                    default: r_op  <= c_OP_READ;
                                endcase
                            end
                            c_ST_ADDR: begin
                                r_byte_idx <= r_byte_idx + 2'd1;
                                if (r_byte_idx == 2'd2) begin
                                    r_mem_addr <= w_addr_load;
                                    if (r_op == c_OP_READ) begin
                                        r_mem_rd <= 1'b1;
                                    end
                                end
                            end
                            c_ST_ID: begin
                                r_tx <= w_id_byte;
                                if (r_byte_idx != 2'd3) begin
                                    r_byte_idx <= r_byte_idx + 2'd1;
                                end
                            end
                            c_ST_STAT: r_tx <= w_stat;
                            c_ST_RD: begin
                                r_mem_addr <= r_mem_addr + ADDR_W'(1);
                                r_mem_rd   <= 1'b1;
                            end
                            c_ST_DUMMY: r_mem_rd <= 1'b1;
                            c_ST_PP: begin
                                r_mem_wr    <= 1'b1;
                                r_mem_wdata <= w_rx_next;
                                r_pp_done   <= 1'b1;
                            end
                            default: r_bitcnt <= 3'd0;
                        endcase
                    end
                end
                if (w_fall_ok) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso  = r_miso;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign wel       = r_wel;

endmodule
`default_nettype wire
